ct_rtu_ptr_expand_cnt: RTL and testbench
========================================

Name: ct_rtu_ptr_expand_cnt

Overview:
Parametrised circular retire-pointer counter with registered one-hot expansion.
- Holds a pointer into a DEPTH-entry ring (default 96, ROB-sized) with a wrap bit.
- Advances by 0..MAX_INC entries per cycle, wrapping modulo a non-power-of-two DEPTH.
- Presents the pointer as a one-hot vector and as a MAX_INC-wide multi-hot window.
- Used by the RTU retire/commit stages to index ROB entries without per-consumer decoders.

Parameters:
DEPTH, 96, number of ring entries (2..2**PTR_W).
PTR_W, 7, pointer width; must satisfy 2**PTR_W >= DEPTH.
MAX_INC, 4, maximum advance per cycle and window width (1..DEPTH-1).
INC_W, 3, width of the advance count; must satisfy 2**INC_W > MAX_INC.

Ports:
forever_cpuclk  in  1  clock; all state updates on the rising edge.
cpurst  in  1  reset, synchronous, active-high.
x_flush  in  1  return the pointer to entry 0 and clear the wrap bit.
x_load_vld  in  1  load the pointer from x_load_ptr and x_load_wrap (recovery).
x_load_ptr  in  PTR_W  pointer value to load.
x_load_wrap  in  1  wrap bit value to load.
x_inc_vld  in  1  advance request.
x_inc_num  in  INC_W  number of entries to advance.
x_ptr  out  PTR_W  current pointer (registered).
x_ptr_wrap  out  1  wrap bit; toggles on each pass through DEPTH-1 to 0.
x_ptr_expand  out  DEPTH  one-hot of x_ptr (registered).
x_win_expand  out  DEPTH  multi-hot with bits x_ptr .. x_ptr+MAX_INC-1, taken modulo DEPTH (registered).
x_err  out  1  one-cycle pulse: illegal load or illegal increment was rejected.

Behaviour:
Reset values
- cpurst=1 at an edge sets x_ptr=0, x_ptr_wrap=0, x_ptr_expand=bit0, x_win_expand=bits[MAX_INC-1:0], x_err=0.
- Reset overrides every other input in that cycle.

Priority, highest first: cpurst > x_flush > x_load_vld > x_inc_vld.
- Only the winning event updates state.
- A lower-priority request asserted in the same cycle is dropped silently; x_err is not raised for it.

Flush
- Next state: ptr=0, wrap=0.

Load
- If x_load_ptr < DEPTH: ptr=x_load_ptr, wrap=x_load_wrap.
- If x_load_ptr >= DEPTH: state holds and x_err pulses next cycle.

Increment
- sum = ptr + x_inc_num, computed at PTR_W+1 bits.
- If sum >= DEPTH: ptr = sum - DEPTH and wrap toggles. Otherwise ptr = sum and wrap holds.
- x_inc_num=0 is legal: no change and no error.
- x_inc_num > MAX_INC is rejected: state holds and x_err pulses.

Latency and output consistency
- Every update is visible on all outputs exactly 1 cycle after the requesting edge.
- No combinational path runs from any input to any output.
- x_ptr_expand and x_win_expand are registered from the same next-pointer value as x_ptr, so all three are always mutually consistent.
- x_err is the only output that pulses; it is high for exactly one cycle per rejected request.

Window generation
- The window wraps across the DEPTH-1 to 0 boundary. Example: ptr=94, MAX_INC=4 gives bits {94,95,0,1}.
- Bits in [DEPTH, 2**PTR_W) are never set in any output.

Invariants (for assertions)
- x_ptr < DEPTH at all times.
- x_ptr_expand is exactly one-hot.
- popcount(x_win_expand) == MAX_INC.

Decomposition:
Shared package ct_rtu_ptr_pkg holds:
- Default DEPTH, PTR_W, MAX_INC and INC_W constants.
- Elaboration-time checks on the parameter constraints listed above.
- A function returning the modulo-DEPTH sum and its wrap flag.

Sub-module ct_rtu_onehot_dec #(DEPTH, PTR_W): purely combinational decode of a pointer to a DEPTH-bit one-hot.
- Instantiated once on the next-pointer value.
- The window is built as the OR of MAX_INC modulo-rotated copies of that one-hot.

Test Plan:
- Reset then idle: x_ptr=0, x_ptr_expand=96'h1, x_win_expand=96'hF, x_ptr_wrap=0, x_err=0.
- ptr=93, inc_num=4: next cycle x_ptr=1, x_ptr_wrap=1, x_ptr_expand bit1 only, x_win_expand bits{1,2,3,4}.
- Load ptr=94 wrap=0: x_win_expand bits{94,95,0,1}; then inc_num=2 gives x_ptr=0, wrap=1.
- Load ptr=100: x_err high for one cycle and state unchanged. Then inc_num=5: x_err high for one cycle and state unchanged.
- Same-cycle flush+load+inc with ptr=50: x_ptr=0, wrap=0. Same-cycle load(10)+inc(3): x_ptr=10.
- cpurst asserted with inc_vld=1 at ptr=60: outputs return to reset values next cycle. Random 10k-cycle run with scoreboard model checks the invariants every cycle.

Source files
------------

// File: rtl/ct_rtu_ptr_pkg.sv
// rtl/ct_rtu_ptr_pkg.sv - shared constants and helpers for the RTU retire-pointer counter
package ct_rtu_ptr_pkg;

  localparam int unsigned RTU_PTR_DEPTH   = 96;
  localparam int unsigned RTU_PTR_W       = 7;
  localparam int unsigned RTU_PTR_MAX_INC = 4;
  localparam int unsigned RTU_PTR_INC_W   = 3;

  typedef struct packed {
    logic [31:0] ptr;
    logic        wrap;
  } mod_sum_t;

  // Ring addition: ptr + inc folded back into [0, depth) with the wrap crossing flagged.
  function automatic mod_sum_t mod_add(input logic [31:0] ptr,
                                       input logic [31:0] inc,
                                       input logic [31:0] depth);
    mod_sum_t    r;
    logic [31:0] sum;
    sum = ptr + inc;
    if (sum >= depth) begin
      r.ptr  = sum - depth;
      r.wrap = 1'b1;
    end else begin
      r.ptr  = sum;
      r.wrap = 1'b0;
    end
    return r;
  endfunction

  // Legal parameter set: pointer covers the ring, window fits inside it, count covers the window.
  function automatic bit params_ok(input int unsigned depth,
                                   input int unsigned ptr_w,
                                   input int unsigned max_inc,
                                   input int unsigned inc_w);
    bit ok;
    ok = (depth >= 2) && (ptr_w >= 1) && (ptr_w < 32) && (inc_w >= 1) && (inc_w < 32);
    if (ok) begin
      ok = ((64'd1 << ptr_w) >= 64'(depth)) &&
           (max_inc >= 1) && (max_inc < depth) &&
           ((64'd1 << inc_w) > 64'(max_inc));
    end
    return ok;
  endfunction

endpackage

// File: rtl/ct_rtu_onehot_dec.sv
// rtl/ct_rtu_onehot_dec.sv - pointer to DEPTH-bit one-hot decoder
module ct_rtu_onehot_dec #(
  parameter int unsigned DEPTH = 96,
  parameter int unsigned PTR_W = 7
) (
  input  logic [PTR_W-1:0] ptr,
  output logic [DEPTH-1:0] onehot
);

  // Only codes below DEPTH can light a bit; codes past the ring decode to zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ptr == PTR_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ct_rtu_ptr_expand_cnt.sv
// rtl/ct_rtu_ptr_expand_cnt.sv - circular retire pointer with registered one-hot and window expansion
module ct_rtu_ptr_expand_cnt
  import ct_rtu_ptr_pkg::*;
#(
  parameter int unsigned DEPTH   = RTU_PTR_DEPTH,
  parameter int unsigned PTR_W   = RTU_PTR_W,
  parameter int unsigned MAX_INC = RTU_PTR_MAX_INC,
  parameter int unsigned INC_W   = RTU_PTR_INC_W
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             x_flush,
  input  logic             x_load_vld,
  input  logic [PTR_W-1:0] x_load_ptr,
  input  logic             x_load_wrap,
  input  logic             x_inc_vld,
  input  logic [INC_W-1:0] x_inc_num,
  output logic [PTR_W-1:0] x_ptr,
  output logic             x_ptr_wrap,
  output logic [DEPTH-1:0] x_ptr_expand,
  output logic [DEPTH-1:0] x_win_expand,
  output logic             x_err
);

  if (!params_ok(DEPTH, PTR_W, MAX_INC, INC_W)) begin : g_param_err
    $error("ct_rtu_ptr_expand_cnt: illegal DEPTH/PTR_W/MAX_INC/INC_W combination");
  end

  localparam logic [PTR_W:0]   DEPTH_EXT = (PTR_W + 1)'(DEPTH);
  localparam logic [INC_W-1:0] MAX_NUM   = INC_W'(MAX_INC);
  localparam logic [DEPTH-1:0] WIN_RST   = {{(DEPTH - MAX_INC){1'b0}}, {MAX_INC{1'b1}}};

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             wrap_q, wrap_d;
  logic [DEPTH-1:0] ptr_exp_q, ptr_exp_d;
  logic [DEPTH-1:0] win_exp_q, win_exp_d;
  logic             err_q, err_d;

  mod_sum_t         inc_sum;
  logic [31:0]      unused_sum_hi;
  logic [DEPTH-1:0] next_onehot;

  assign unused_sum_hi = inc_sum.ptr;

  // Next pointer by priority: flush, then load, then increment; illegal requests hold and flag.
  always_comb begin
    ptr_d   = ptr_q;
    wrap_d  = wrap_q;
    err_d   = 1'b0;
    inc_sum = mod_add(32'(ptr_q), 32'(x_inc_num), 32'(DEPTH));
    if (x_flush) begin
      ptr_d  = '0;
      wrap_d = 1'b0;
    end else if (x_load_vld) begin
      if ({1'b0, x_load_ptr} < DEPTH_EXT) begin
        ptr_d  = x_load_ptr;
        wrap_d = x_load_wrap;
      end else begin
        err_d = 1'b1;
      end
    end else if (x_inc_vld) begin
      if (x_inc_num > MAX_NUM) begin
        err_d = 1'b1;
      end else begin
        ptr_d  = inc_sum.ptr[PTR_W-1:0];
        wrap_d = wrap_q ^ inc_sum.wrap;
      end
    end
  end

  ct_rtu_onehot_dec #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_next_dec (
    .ptr    (ptr_d),
    .onehot (next_onehot)
  );

  // Expansions come from the same next pointer as ptr_q so all outputs agree every cycle.
  always_comb begin
    ptr_exp_d = next_onehot;
    win_exp_d = '0;
    for (int k = 0; k < int'(MAX_INC); k++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        win_exp_d[i] = win_exp_d[i] | next_onehot[(i + int'(DEPTH) - k) % int'(DEPTH)];
      end
    end
  end

  // State register; reset wins over every request in the same cycle.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ptr_q     <= '0;
      wrap_q    <= 1'b0;
      ptr_exp_q <= {{(DEPTH - 1){1'b0}}, 1'b1};
      win_exp_q <= WIN_RST;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      wrap_q    <= wrap_d;
      ptr_exp_q <= ptr_exp_d;
      win_exp_q <= win_exp_d;
      err_q     <= err_d;
    end
  end

  assign x_ptr        = ptr_q;
  assign x_ptr_wrap   = wrap_q;
  assign x_ptr_expand = ptr_exp_q;
  assign x_win_expand = win_exp_q;
  assign x_err        = err_q;

endmodule

// File: tb/tb_ct_rtu_ptr_expand_cnt.sv
// tb/tb_ct_rtu_ptr_expand_cnt.sv - randomized self-checking bench for ct_rtu_ptr_expand_cnt
module tb_ct_rtu_ptr_expand_cnt;

  localparam int DEPTH   = 96;
  localparam int PTR_W   = 7;
  localparam int MAX_INC = 4;
  localparam int INC_W   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             load_vld;
  logic [PTR_W-1:0] load_ptr;
  logic             load_wrap;
  logic             inc_vld;
  logic [INC_W-1:0] inc_num;
  logic [PTR_W-1:0] x_ptr;
  logic             x_ptr_wrap;
  logic [DEPTH-1:0] x_ptr_expand;
  logic [DEPTH-1:0] x_win_expand;
  logic             x_err;

  int checks = 0;
  int errors = 0;

  // Model: position in a 2*DEPTH lap; pointer is pos mod DEPTH, wrap is which lap.
  int m_pos = 0;
  bit m_err = 1'b0;

  ct_rtu_ptr_expand_cnt dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .x_flush        (flush),
    .x_load_vld     (load_vld),
    .x_load_ptr     (load_ptr),
    .x_load_wrap    (load_wrap),
    .x_inc_vld      (inc_vld),
    .x_inc_num      (inc_num),
    .x_ptr          (x_ptr),
    .x_ptr_wrap     (x_ptr_wrap),
    .x_ptr_expand   (x_ptr_expand),
    .x_win_expand   (x_win_expand),
    .x_err          (x_err)
  );

  always #5 clk = ~clk;

  function automatic int exp_ptr();
    return m_pos % DEPTH;
  endfunction

  function automatic bit exp_wrap();
    return (m_pos >= DEPTH);
  endfunction

  function automatic logic [DEPTH-1:0] exp_onehot(input int p);
    logic [DEPTH-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [DEPTH-1:0] exp_window(input int p);
    logic [DEPTH-1:0] v;
    v = '0;
    for (int k = 0; k < MAX_INC; k++) v[(p + k) % DEPTH] = 1'b1;
    return v;
  endfunction

  // One clock with the given request set; the model steps at the edge, inputs return to idle after.
  task automatic apply(input bit r, input bit f, input bit ld, input int lp, input bit lw,
                       input bit iv, input int n);
    rst       = r;
    flush     = f;
    load_vld  = ld;
    load_ptr  = PTR_W'(lp);
    load_wrap = lw;
    inc_vld   = iv;
    inc_num   = INC_W'(n);
    @(posedge clk);
    m_err = 1'b0;
    if (r) m_pos = 0;
    else if (f) m_pos = 0;
    else if (ld) begin
      if (lp < DEPTH) m_pos = lp + (lw ? DEPTH : 0);
      else m_err = 1'b1;
    end else if (iv) begin
      if (n > MAX_INC) m_err = 1'b1;
      else m_pos = (m_pos + n) % (2 * DEPTH);
    end
    #1;
    rst = 1'b0; flush = 1'b0; load_vld = 1'b0; inc_vld = 1'b0;
    load_ptr = '0; load_wrap = 1'b0; inc_num = '0;
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++; if (x_ptr !== 7'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", x_ptr); end
    checks++; if (x_ptr_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b want 0", x_ptr_wrap); end
    checks++; if (x_ptr_expand !== 96'h1) begin errors++; $display("FAIL reset_expand got %h want 1", x_ptr_expand); end
    checks++; if (x_win_expand !== 96'hF) begin errors++; $display("FAIL reset_win got %h want f", x_win_expand); end
    checks++; if (x_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", x_err); end
  endtask

  task automatic test_wrap_inc();
    apply(0, 0, 1, 93, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 1, 4);
    checks++; if (x_ptr !== 7'd1) begin errors++; $display("FAIL wrap_inc_ptr got %0d want 1", x_ptr); end
    checks++; if (x_ptr_wrap !== 1'b1) begin errors++; $display("FAIL wrap_inc_wrap got %0b want 1", x_ptr_wrap); end
    checks++; if (x_ptr_expand !== 96'h2) begin errors++; $display("FAIL wrap_inc_expand got %h want 2", x_ptr_expand); end
    checks++; if (x_win_expand !== 96'h1E) begin errors++; $display("FAIL wrap_inc_win got %h want 1e", x_win_expand); end
  endtask

  task automatic test_window_wrap();
    logic [DEPTH-1:0] want;
    want = '0;
    want[94] = 1'b1; want[95] = 1'b1; want[0] = 1'b1; want[1] = 1'b1;
    apply(0, 0, 1, 94, 0, 0, 0);
    checks++; if (x_win_expand !== want) begin errors++; $display("FAIL win_wrap got %h want %h", x_win_expand, want); end
    checks++; if (x_ptr !== 7'd94) begin errors++; $display("FAIL win_wrap_ptr got %0d want 94", x_ptr); end
    apply(0, 0, 0, 0, 0, 1, 2);
    checks++; if (x_ptr !== 7'd0) begin errors++; $display("FAIL edge_inc_ptr got %0d want 0", x_ptr); end
    checks++; if (x_ptr_wrap !== 1'b1) begin errors++; $display("FAIL edge_inc_wrap got %0b want 1", x_ptr_wrap); end
  endtask

  task automatic test_errors();
    apply(0, 0, 1, 30, 1, 0, 0);
    apply(0, 0, 1, 100, 0, 0, 0);
    checks++; if (x_err !== 1'b1) begin errors++; $display("FAIL bad_load_err got %0b want 1", x_err); end
    checks++; if (x_ptr !== 7'd30 || x_ptr_wrap !== 1'b1) begin errors++; $display("FAIL bad_load_hold got %0d/%0b want 30/1", x_ptr, x_ptr_wrap); end
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++; if (x_err !== 1'b0) begin errors++; $display("FAIL bad_load_pulse got %0b want 0", x_err); end
    apply(0, 0, 0, 0, 0, 1, 5);
    checks++; if (x_err !== 1'b1) begin errors++; $display("FAIL bad_inc_err got %0b want 1", x_err); end
    checks++; if (x_ptr !== 7'd30) begin errors++; $display("FAIL bad_inc_hold got %0d want 30", x_ptr); end
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++; if (x_err !== 1'b0) begin errors++; $display("FAIL bad_inc_pulse got %0b want 0", x_err); end
    apply(0, 0, 0, 0, 0, 1, 0);
    checks++; if (x_ptr !== 7'd30 || x_err !== 1'b0) begin errors++; $display("FAIL inc_zero got %0d/%0b want 30/0", x_ptr, x_err); end
  endtask

  task automatic test_priority();
    apply(0, 0, 1, 50, 1, 0, 0);
    apply(0, 1, 1, 10, 1, 1, 3);
    checks++; if (x_ptr !== 7'd0 || x_ptr_wrap !== 1'b0) begin errors++; $display("FAIL prio_flush got %0d/%0b want 0/0", x_ptr, x_ptr_wrap); end
    apply(0, 0, 1, 10, 0, 1, 3);
    checks++; if (x_ptr !== 7'd10) begin errors++; $display("FAIL prio_load got %0d want 10", x_ptr); end
    apply(0, 1, 1, 120, 0, 1, 7);
    checks++; if (x_err !== 1'b0 || x_ptr !== 7'd0) begin errors++; $display("FAIL prio_drop got %0d/%0b want 0/0", x_ptr, x_err); end
    apply(0, 0, 1, 20, 0, 1, 6);
    checks++; if (x_err !== 1'b0 || x_ptr !== 7'd20) begin errors++; $display("FAIL prio_load_inc got %0d/%0b want 20/0", x_ptr, x_err); end
  endtask

  task automatic test_reset_override();
    apply(0, 0, 1, 60, 1, 0, 0);
    apply(1, 0, 0, 0, 0, 1, 3);
    checks++; if (x_ptr !== 7'd0 || x_ptr_wrap !== 1'b0) begin errors++; $display("FAIL rst_over_ptr got %0d/%0b want 0/0", x_ptr, x_ptr_wrap); end
    checks++; if (x_ptr_expand !== 96'h1 || x_win_expand !== 96'hF) begin errors++; $display("FAIL rst_over_vec got %h/%h want 1/f", x_ptr_expand, x_win_expand); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      bit r, f, ld, lw, iv;
      int lp, n;
      r  = ($urandom_range(0, 999) < 5);
      f  = ($urandom_range(0, 99) < 3);
      ld = ($urandom_range(0, 99) < 8);
      lp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(96, 127)) : int'($urandom_range(0, 95));
      lw = 1'($urandom);
      iv = ($urandom_range(0, 99) < 75);
      n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      apply(r, f, ld, lp, lw, iv, n);
      checks++;
      if (x_ptr !== PTR_W'(exp_ptr()) || x_ptr_wrap !== exp_wrap() || x_err !== m_err) begin
        errors++;
        $display("FAIL rand_state cyc %0d got ptr %0d wrap %0b err %0b want %0d %0b %0b",
                 c, x_ptr, x_ptr_wrap, x_err, exp_ptr(), exp_wrap(), m_err);
      end
      checks++;
      if (x_ptr_expand !== exp_onehot(exp_ptr()) || x_win_expand !== exp_window(exp_ptr())) begin
        errors++;
        $display("FAIL rand_vec cyc %0d got %h/%h want %h/%h", c, x_ptr_expand, x_win_expand,
                 exp_onehot(exp_ptr()), exp_window(exp_ptr()));
      end
      checks++;
      if (!(int'(x_ptr) < DEPTH) || $countones(x_ptr_expand) != 1 || $countones(x_win_expand) != MAX_INC) begin
        errors++;
        $display("FAIL rand_invariant cyc %0d got ptr %0d ones %0d win %0d want <96 1 4", c, x_ptr,
                 $countones(x_ptr_expand), $countones(x_win_expand));
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; load_vld = 1'b0; load_ptr = '0; load_wrap = 1'b0;
    inc_vld = 1'b0; inc_num = '0;
    test_reset();
    test_wrap_inc();
    test_window_wrap();
    test_errors();
    test_priority();
    test_reset_override();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
